arquitetura_robot_command_out: RTL
==================================

# arquitetura_robot_command_out

Avalon-MM slave output port that drives robot command lines (direction and shoot) from the Nios II processor. It is the write-side counterpart to the direction/shoot input port. It holds a level register with atomic set/clear access and a self-timing pulse register, so firmware can fire a fixed-width "shoot" strobe without busy-waiting. It sits on the system interconnect beside the input PIOs, and its `out_port` goes to the robot interface pins.

## Interface
Parameters:
- `WIDTH`, 3: number of command lines driven on `out_port` (1..31).
- `PULSE_CYCLES`, 1000: length of a pulse in `clk` cycles (≥1).

Ports:
- `clk` in 1: single system clock; all logic on rising edge.
- `reset` in 1: reset is synchronous and active-high.
- `chipselect` in 1: slave selected this cycle.
- `address` in 2: register select (0 data, 1 set, 2 clear, 3 pulse).
- `write_n` in 1: active-low write strobe, qualified by `chipselect`.
- `writedata` in 32: write data; only bits `[WIDTH-1:0]` are used.
- `readdata` out 32: registered read data.
- `out_port` out WIDTH: command lines, `data_reg | pulse_mask`, registered.

## Operation
- Write = `chipselect & ~write_n`. Accepted in one cycle; no wait states.
- addr 0 write: `data_reg <= writedata[WIDTH-1:0]`.
- addr 1 write: `data_reg <= data_reg | writedata`. This is a set.
- addr 2 write: `data_reg <= data_reg & ~writedata`. This is a clear.
- addr 3 write, nonzero: `pulse_mask <= pulse_mask | writedata`, and `pulse_cnt <= PULSE_CYCLES`. Retriggering restarts the full width for all active bits.
- addr 3 write, zero: cancel. `pulse_mask <= 0` and `pulse_cnt <= 0`.
- Pulse state machine:
  - IDLE: `pulse_cnt == 0` and `mask == 0`.
  - ACTIVE: `pulse_cnt > 0`. `pulse_cnt` decrements by 1 per cycle.
  - On the cycle `pulse_cnt` is 1, the next edge clears `pulse_mask`.
- Readdata is updated every cycle, zero-extended:
  - addr 0: `data_reg`.
  - addr 1 and 2: 0.
  - addr 3: `{busy, 0…, pulse_mask}`, with `busy` = (`pulse_cnt != 0`) in bit 31.
- `out_port <= next_data_reg | next_pulse_mask`. This is registered, glitch-free, and has no combinational path from the bus.
- Counter width is `$clog2(PULSE_CYCLES+1)`. Decrement saturates at 0 and never wraps.

## Timing
- Reset values (on the first `clk` edge with `reset`=1): `data_reg`, `pulse_mask`, `pulse_cnt`, `readdata` and `out_port` all become 0.
- Write latency: a write sampled at edge N is reflected on `out_port` after edge N.
- Read latency: `readdata` is valid one cycle after `address` is presented. `readdata` is updated every cycle.
- Pulse width: a nonzero addr-3 write at edge N holds its bits high on `out_port` from edge N to edge N+`PULSE_CYCLES`. That is exactly `PULSE_CYCLES` cycles.
- Expiry and new write in the same cycle: the write wins. The mask becomes the new bits only (old mask expired), and the count reloads.
- Cancel and expiry in the same cycle: the result is 0 either way.
- Bit set in both `data_reg` and `pulse_mask`: the line stays high after the pulse ends.
- Reset mid-pulse: the pulse is aborted and `out_port` is 0 after that edge. Reset has priority over any concurrent write.
- Writes with `chipselect`=0 or `write_n`=1 have no effect.

## Configuration
- Macro `ROBOT_CMD_PULSE_EN`.
- Defined: pulse register, counter and `busy` are present, as described above.
- Undefined: no counter or mask logic is synthesized. Addr-3 writes are ignored, addr-3 reads return 0, and `out_port` equals `data_reg`. Address 0–2 behaviour and all timing are unchanged.

## Test plan
All scenarios use `WIDTH`=3 and `PULSE_CYCLES`=4.
- Reset: hold `reset` for 2 cycles after random writes -> `out_port`=0, `readdata`=0, addr-3 read = 0x00000000.
- Level access: write addr 0 = 0x5, then addr 1 = 0x2, then addr 2 = 0x4 -> `out_port` is 0x5, 0x7, 0x3 after successive edges; addr-0 read returns 0x3 one cycle later.
- Pulse: write addr 3 = 0x4 with `data_reg`=0x1 -> `out_port`=0x5 for exactly 4 cycles, then 0x1. An addr-3 read during the pulse returns 0x80000004, and after the pulse returns 0.
- Retrigger and expiry collision: write addr 3 = 0x4, then write addr 3 = 0x2 on the cycle `pulse_cnt`=1 -> `out_port`=0x2 only, held for 4 more cycles.
- Cancel and reset mid-pulse: start a 0x4 pulse, write addr 3 = 0 at cycle 2 -> `out_port`=0 next edge. Repeat with `reset` at cycle 2 -> same result, `busy`=0.
- Macro off: rebuild without `ROBOT_CMD_PULSE_EN` and write addr 3 = 0x7 -> `out_port` unchanged, addr-3 read = 0.

Source files
------------

// File: rtl/arquitetura_robot_command_out.sv
// rtl/arquitetura_robot_command_out.sv - Avalon-MM command output port with set/clear level register and self-timed pulse register.
// Optional pulse register, counter and busy flag are built only when ROBOT_CMD_PULSE_EN is defined.
module arquitetura_robot_command_out #(
   parameter int WIDTH        = 3,
   parameter int PULSE_CYCLES = 1000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             chipselect,
   input  logic [1:0]       address,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);

   logic             wr;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] data_reg;
   logic [WIDTH-1:0] next_data;
   logic [31:0]      next_readdata;

   assign wr    = chipselect & ~write_n;
   assign wdata = writedata[WIDTH-1:0];

   always_comb begin
      next_data = data_reg;
      if (wr) begin
         case (address)
            2'd0:    next_data = wdata;
            2'd1:    next_data = data_reg | wdata;
            2'd2:    next_data = data_reg & ~wdata;
            default: next_data = data_reg;
         endcase
      end
   end

`ifdef ROBOT_CMD_PULSE_EN
   localparam int CW = $clog2(PULSE_CYCLES + 1);

   typedef enum logic {IDLE, ACTIVE} pulse_state_t;

   pulse_state_t     pulse_state, next_state;
   logic [CW-1:0]    pulse_cnt, next_cnt;
   logic [WIDTH-1:0] pulse_mask, next_mask;
   logic             busy;

   assign busy = (pulse_cnt != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         pulse_state <= IDLE;
         pulse_cnt   <= '0;
         pulse_mask  <= '0;
      end else begin
         pulse_state <= next_state;
         pulse_cnt   <= next_cnt;
         pulse_mask  <= next_mask;
      end
   end

   // Expiry is resolved first so a same-cycle write sees an empty mask and reloads the count.
   always_comb begin
      next_state = pulse_state;
      next_cnt   = pulse_cnt;
      next_mask  = pulse_mask;
      if (pulse_state == ACTIVE && pulse_cnt != '0) begin
         next_cnt = pulse_cnt - CW'(1);
         if (pulse_cnt == CW'(1)) begin
            next_mask  = '0;
            next_state = IDLE;
         end
      end
      if (wr && address == 2'd3) begin
         if (wdata != '0) begin
            next_mask  = next_mask | wdata;
            next_cnt   = CW'(PULSE_CYCLES);
            next_state = ACTIVE;
         end else begin
            next_mask  = '0;
            next_cnt   = '0;
            next_state = IDLE;
         end
      end
   end

   always_comb begin
      next_readdata = '0;
      case (address)
         2'd0: next_readdata[WIDTH-1:0] = data_reg;
         2'd3: begin
            next_readdata[WIDTH-1:0] = pulse_mask;
            next_readdata[31]        = busy;
         end
         default: next_readdata = '0;
      endcase
   end
`else
   logic [WIDTH-1:0] next_mask;

   assign next_mask = '0;

   always_comb begin
      next_readdata = '0;
      if (address == 2'd0) next_readdata[WIDTH-1:0] = data_reg;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         data_reg <= '0;
         readdata <= '0;
         out_port <= '0;
      end else begin
         data_reg <= next_data;
         readdata <= next_readdata;
         out_port <= next_data | next_mask;
      end
   end

endmodule
